// File: rtl/bcd_scan_display_if.sv
// Signal bundle between the count/control source and the BCD scan display block.
interface bcd_scan_display_if #(
    parameter int DIGITS = 4
);
    logic                  countup;
    logic                  clear;
    logic                  hold;
    logic [4*DIGITS-1:0]   value;
    logic                  overflow;
    logic [7:0]            seg;
    logic [DIGITS-1:0]     dig;

    modport master (
        output countup, clear, hold,
        input  value, overflow, seg, dig
    );

    modport slave (
        input  countup, clear, hold,
        output value, overflow, seg, dig
    );
endinterface

// File: rtl/bcd_scan_display.sv
// BCD event counter with a multiplexed 7-segment scan driver (blank gap per digit slot).
// Optional leading-zero blanking is enabled by defining BCD_SCAN_LZB_EN.
module bcd_scan_display #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1024,
    parameter int BLANK    = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    bcd_scan_display_if.slave bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] P_GAP_END = PW'(BLANK - 1);
    localparam logic [PW-1:0] P_LAST    = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] I_LAST    = IW'(DIGITS - 1);
    localparam logic [0:0]    S_BLANK   = 1'b0;
    localparam logic [0:0]    S_DRIVE   = 1'b1;

    logic                countup_d;
    logic                inc;
    logic [4*DIGITS-1:0] count;
    logic [4*DIGITS-1:0] count_nxt;
    logic                carry;
    logic                ovf;
    logic [PW-1:0]       pcnt;
    logic [IW-1:0]       idx;
    logic [0:0]          state;
    logic [7:0]          seg_r;
    logic [7:0]          seg_nxt;
    logic [DIGITS-1:0]   dig_r;
    logic [DIGITS-1:0]   dig_nxt;
    logic [3:0]          nib;
    logic                blank_lz;
`ifdef BCD_SCAN_LZB_EN
    logic                zeros_above;
`endif

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h00;
        endcase
    endfunction

    assign inc = bus.countup & ~countup_d & ~hold_in();

    function automatic logic hold_in();
        hold_in = bus.hold;
    endfunction

    // Ripple carry: a digit only moves while every lower digit was 9; carry out means wrap.
    always_comb begin
        count_nxt = count;
        carry     = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (count[4*k +: 4] == 4'd9) begin
                    count_nxt[4*k +: 4] = 4'd0;
                end else begin
                    count_nxt[4*k +: 4] = count[4*k +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            countup_d <= 1'b0;
            count     <= '0;
            ovf       <= 1'b0;
        end else begin
            countup_d <= bus.countup;
            if (bus.clear) begin
                count <= '0;
                ovf   <= 1'b0;
            end else if (inc) begin
                count <= count_nxt;
                if (carry) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        nib      = 4'd0;
        blank_lz = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (IW'(k) == idx) begin
                nib = count[4*k +: 4];
            end
        end
`ifdef BCD_SCAN_LZB_EN
        zeros_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zeros_above = zeros_above & (count[4*k +: 4] == 4'd0);
            if (IW'(k) == idx) begin
                blank_lz = zeros_above;
            end
        end
`endif
        seg_nxt = {(idx == '0) & ovf, blank_lz ? 7'h00 : decode(nib)};
        dig_nxt = DIGITS'(1) << idx;
    end

    // Slot timing: blank for pcnt 0..BLANK-1, drive for the rest, index steps at prescaler wrap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pcnt  <= '0;
            idx   <= '0;
            state <= S_BLANK;
            seg_r <= 8'h00;
            dig_r <= '0;
        end else begin
            pcnt <= (pcnt == P_LAST) ? '0 : pcnt + PW'(1);
            if (pcnt == P_LAST) begin
                idx <= (idx == I_LAST) ? '0 : idx + IW'(1);
            end
            case (state)
                S_BLANK: begin
                    if (pcnt == P_GAP_END) begin
                        state <= S_DRIVE;
                        seg_r <= seg_nxt;
                        dig_r <= dig_nxt;
                    end else begin
                        seg_r <= 8'h00;
                        dig_r <= '0;
                    end
                end
                default: begin
                    if (pcnt == P_LAST) begin
                        state <= S_BLANK;
                        seg_r <= 8'h00;
                        dig_r <= '0;
                    end else begin
                        seg_r <= seg_nxt;
                        dig_r <= dig_nxt;
                    end
                end
            endcase
        end
    end

    assign bus.value    = count;
    assign bus.overflow = ovf;
    assign bus.seg      = seg_r;
    assign bus.dig      = dig_r;
endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed scoreboard bench for bcd_scan_display (DIGITS=4, SCAN_DIV=16, BLANK=4).
module tb_bcd_scan_display;
    logic clock;
    logic reset_n;

    bcd_scan_display_if #(.DIGITS(4)) bus ();

    bcd_scan_display #(
        .DIGITS   (4),
        .SCAN_DIV (16),
        .BLANK    (4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   model    = 0;

`ifdef BCD_SCAN_LZB_EN
    localparam logic [7:0] LZ_SEG = 8'h00;
`else
    localparam logic [7:0] LZ_SEG = 8'h3F;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    function automatic logic [15:0] to_bcd(input int n);
        int          d;
        logic [15:0] r;
        d = n;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(d % 10);
            d           = d / 10;
        end
        return r;
    endfunction

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%0h expected=entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse();
        bus.countup = 1'b1;
        tick();
        bus.countup = 1'b0;
        tick();
    endtask

    task automatic wait_dig(input logic [3:0] d, output bit ok);
        logic [3:0] prev;
        prev = bus.dig;
        ok   = 1'b0;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (bus.dig == d && prev != d) begin
                ok = 1'b1;
                return;
            end
            prev = bus.dig;
        end
    endtask

    task automatic blank_start();
        for (int c = 1; c <= 3; c++) begin
            tick();
            push("start_gap_dig", 32'h0);
            pop_check(32'(bus.dig));
        end
        tick();
        push("first_slot_dig", 32'h1);
        pop_check(32'(bus.dig));
    endtask

    task automatic scan_check(input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] es [4];
        bit         ok;
        int         n;
        int         g;
        es[0] = e0; es[1] = e1; es[2] = e2; es[3] = e3;
        wait_dig(4'b0001, ok);
        push("scan_sync", 32'h1);
        pop_check(32'(ok));
        for (int s = 0; s < 4; s++) begin
            push("scan_dig", 32'(4'b0001 << s));
            push("scan_seg", 32'(es[s]));
            pop_check(32'(bus.dig));
            pop_check(32'(bus.seg));
            n = 1;
            while (n < 40) begin
                tick();
                if (bus.dig != 4'(4'b0001 << s)) break;
                n++;
            end
            push("slot_len", 32'd12);
            pop_check(32'(n));
            g = 0;
            while (bus.dig == 4'b0000 && g < 40) begin
                g++;
                tick();
            end
            push("gap_len", 32'd4);
            pop_check(32'(g));
        end
    endtask

    initial begin
        bit ok;
        reset_n     = 1'b0;
        bus.countup = 1'b0;
        bus.clear   = 1'b0;
        bus.hold    = 1'b0;

        // Reset with countup toggling
        for (int i = 0; i < 6; i++) begin
            bus.countup = ~bus.countup;
            tick();
        end
        push("rst_value", 32'h0);    pop_check(32'(bus.value));
        push("rst_seg", 32'h0);      pop_check(32'(bus.seg));
        push("rst_dig", 32'h0);      pop_check(32'(bus.dig));
        push("rst_overflow", 32'h0); pop_check(32'(bus.overflow));
        bus.countup = 1'b0;
        reset_n     = 1'b1;
        blank_start();
        push("first_slot_seg", 32'h3F);
        pop_check(32'(bus.seg));

        // Single pulse, then a held level counts once
        bus.countup = 1'b1;
        push("pulse_value", 32'h0001);
        tick();
        pop_check(32'(bus.value));
        repeat (50) tick();
        push("held_value", 32'h0001);
        pop_check(32'(bus.value));
        bus.countup = 1'b0;
        tick();

        // Clear with coincident edge, then count to 9999 and wrap
        bus.clear   = 1'b1;
        bus.countup = 1'b1;
        tick();
        bus.clear   = 1'b0;
        bus.countup = 1'b0;
        push("clear_value", 32'h0); pop_check(32'(bus.value));
        tick();
        model = 0;
        for (int i = 0; i < 9999; i++) begin
            model++;
            push("count_value", 32'(to_bcd(model)));
            pulse();
            pop_check(32'(bus.value));
        end
        push("pre_wrap_overflow", 32'h0); pop_check(32'(bus.overflow));
        push("wrap_value", 32'h0);
        push("wrap_overflow", 32'h1);
        pulse();
        pop_check(32'(bus.value));
        pop_check(32'(bus.overflow));
        wait_dig(4'b0001, ok);
        push("dp_sync", 32'h1);   pop_check(32'(ok));
        push("dp_digit0", 32'hBF); pop_check(32'(bus.seg));
        wait_dig(4'b0010, ok);
        push("dp_sync1", 32'h1);  pop_check(32'(ok));
        push("no_dp_digit1", 32'h3F); pop_check(32'(bus.seg));

        // Clear beats a coincident edge and resets overflow
        bus.clear   = 1'b1;
        bus.countup = 1'b1;
        tick();
        bus.clear   = 1'b0;
        bus.countup = 1'b0;
        push("clr_edge_value", 32'h0);    pop_check(32'(bus.value));
        push("clr_edge_overflow", 32'h0); pop_check(32'(bus.overflow));
        tick();

        // Hold ignores edges; hold with clear still clears
        bus.hold = 1'b1;
        repeat (5) pulse();
        push("hold_value", 32'h0); pop_check(32'(bus.value));
        bus.hold = 1'b0;
        pulse();
        push("post_hold_value", 32'h1); pop_check(32'(bus.value));
        bus.hold  = 1'b1;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.hold  = 1'b0;
        push("hold_clear_value", 32'h0); pop_check(32'(bus.value));
        pulse();
        push("after_hold_clear", 32'h1); pop_check(32'(bus.value));

        // Scan pattern for 1234
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        for (int i = 0; i < 1234; i++) pulse();
        push("preset_1234", 32'h1234); pop_check(32'(bus.value));
        scan_check(8'h66, 8'h4F, 8'h5B, 8'h06);

        // Mid-slot counter change shows on seg one cycle later
        wait_dig(4'b0001, ok);
        push("mid_sync", 32'h1); pop_check(32'(ok));
        bus.countup = 1'b1;
        tick();
        bus.countup = 1'b0;
        push("mid_value", 32'h1235); pop_check(32'(bus.value));
        push("mid_seg_old", 32'h66); pop_check(32'(bus.seg));
        tick();
        push("mid_seg_new", 32'h6D); pop_check(32'(bus.seg));

        // Reset mid-slot clears outputs at once and restarts in blank
        reset_n = 1'b0;
        #1;
        push("midrst_dig", 32'h0);   pop_check(32'(bus.dig));
        push("midrst_seg", 32'h0);   pop_check(32'(bus.seg));
        push("midrst_value", 32'h0); pop_check(32'(bus.value));
        tick();
        reset_n = 1'b1;
        blank_start();

        // Leading zeros for 0007
        for (int i = 0; i < 7; i++) pulse();
        push("preset_7", 32'h0007); pop_check(32'(bus.value));
        scan_check(8'h07, LZ_SEG, LZ_SEG, LZ_SEG);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
